// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared constants and types for the matrix-multiplier result path.
//   LANES / IN_WIDTH / OUT_WIDTH / SHIFT_W : result vector geometry
//   OUT_MAX / OUT_MIN                      : signed output byte range
//   state_t                                : drain FSM state encoding
// ---------------------------------------------------------------------------
package matmul_pkg;

  localparam int LANES     = 8;
  localparam int IN_WIDTH  = 32;
  localparam int OUT_WIDTH = 8;
  localparam int SHIFT_W   = 5;
  localparam int IDX_W     = 3;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/matmul_result_drain_requant_lane.sv
// ---------------------------------------------------------------------------
// requant_lane
// Purely combinational requantizer for one 32-bit signed accumulator lane.
// Applies round-half-up, an arithmetic right shift, optional ReLU and
// saturation to a signed byte.
//   lane   : signed accumulator value
//   shift  : right-shift amount
//   result : requantized two's-complement byte
//   sat    : high when the value had to be clamped to the byte range
// ---------------------------------------------------------------------------
module requant_lane
  import matmul_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic [IN_WIDTH-1:0]  lane,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 sat
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int EXT_W = IN_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] HI_LIM = EXT_W'(OUT_MAX);
  localparam logic signed [EXT_W-1:0] LO_LIM = EXT_W'(OUT_MIN);

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shifted;
  logic signed [EXT_W-1:0] clipped;

  // Round, shift and clamp. ReLU zeroing happens before the saturation test,
  // so a negative value removed by ReLU never counts as a saturation event.
  always_comb begin
    ext     = {lane[IN_WIDTH-1], lane};
    rnd     = '0;
    if (shift != '0) begin
      rnd = EXT_W'(1) <<< (shift - SHIFT_W'(1));
    end
    shifted = (ext + rnd) >>> shift;
    clipped = shifted;
    if (RELU_EN && shifted[EXT_W-1]) begin
      clipped = '0;
    end
    sat    = 1'b0;
    result = clipped[OUT_WIDTH-1:0];
    if (clipped > HI_LIM) begin
      result = OUT_WIDTH'(OUT_MAX);
      sat    = 1'b1;
    end else if (clipped < LO_LIM) begin
      result = OUT_WIDTH'(OUT_MIN);
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/matmul_result_drain.sv
// ---------------------------------------------------------------------------
// matmul_result_drain
// Captures the multiplier's 8x32-bit result vector on its done pulse and
// streams the requantized bytes out one per valid/ready transfer.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   en_i          : allows new captures (does not pause an active stream)
//   done_i        : producer pulse, matmul_i/shift_i valid this cycle
//   matmul_i      : result vector, lane k at bits [32k+31:32k]
//   shift_i       : requant right-shift amount
//   ready_i       : downstream accepts a byte
//   valid_o       : data_o/idx_o/last_o valid
//   data_o        : requantized byte
//   idx_o         : lane index of data_o
//   last_o        : final lane of the vector
//   busy_o        : a vector is being streamed
//   ovf_o         : sticky, a done_i was dropped
//   sat_o         : sticky, a transferred lane saturated
// ---------------------------------------------------------------------------
module matmul_result_drain
  import matmul_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic                      done_i,
  input  logic [LANES*IN_WIDTH-1:0] matmul_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [OUT_WIDTH-1:0]      data_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      ovf_o,
  output logic                      sat_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t              state_q;
  state_t              state_d;
  logic [IN_WIDTH-1:0] cap_q [LANES];
  logic [SHIFT_W-1:0]  shift_q;
  logic [IDX_W-1:0]    idx_q;
  logic                ovf_q;
  logic                sat_q;

  logic                xfer;
  logic                is_last;
  logic                capture;
  logic                advance;
  logic                drop;
  logic                lane_sat;
  logic [OUT_WIDTH-1:0] lane_byte;

  assign valid_o = (state_q == STREAM);
  assign busy_o  = (state_q == STREAM);
  assign is_last = (idx_q == LAST_IDX);
  assign xfer    = valid_o && ready_i;
  assign idx_o   = idx_q;
  assign last_o  = valid_o && is_last;
  assign data_o  = lane_byte;
  assign ovf_o   = ovf_q;
  assign sat_o   = sat_q;

  requant_lane #(
    .RELU_EN (RELU_EN)
  ) u_requant (
    .lane   (cap_q[idx_q]),
    .shift  (shift_q),
    .result (lane_byte),
    .sat    (lane_sat)
  );

  // Next-state logic. A done pulse landing on the final transfer is taken
  // straight away so consecutive vectors stream with no idle bubble; any
  // other done pulse during a stream is discarded and flagged.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && done_i) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
        if (en_i && done_i) begin
          if (xfer && is_last) begin
            capture = 1'b1;
            state_d = STREAM;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture register, shift amount and lane index. The index is parked at
  // zero after the final transfer so it is ready for the next vector.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < LANES; k++) begin
        cap_q[k] <= '0;
      end
      shift_q <= '0;
      idx_q   <= '0;
    end else if (capture) begin
      for (int k = 0; k < LANES; k++) begin
        cap_q[k] <= matmul_i[k*IN_WIDTH +: IN_WIDTH];
      end
      shift_q <= shift_i;
      idx_q   <= '0;
    end else if (advance) begin
      idx_q <= idx_q + IDX_W'(1);
    end else if (xfer && is_last) begin
      idx_q <= '0;
    end
  end

  // Sticky status flags; saturation is recorded when the clamped lane is
  // actually handed downstream.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (xfer && lane_sat) begin
        sat_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// ---------------------------------------------------------------------------
// tb_matmul_result_drain
// Directed self-checking bench for matmul_result_drain.
// ---------------------------------------------------------------------------
module tb_matmul_result_drain;

  logic         clk_i;
  logic         rstn_i;
  logic         en_i;
  logic         done_i;
  logic [255:0] matmul_i;
  logic [4:0]   shift_i;
  logic         ready_i;
  logic         valid_o;
  logic [7:0]   data_o;
  logic [2:0]   idx_o;
  logic         last_o;
  logic         busy_o;
  logic         ovf_o;
  logic         sat_o;

  int checks;
  int errors;

  logic [31:0] lane_v [8];
  logic [7:0]  exp_d  [8];

  matmul_result_drain #(
    .RELU_EN (1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (en_i),
    .done_i   (done_i),
    .matmul_i (matmul_i),
    .shift_i  (shift_i),
    .ready_i  (ready_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .idx_o    (idx_o),
    .last_o   (last_o),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o),
    .sat_o    (sat_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] pack_lanes();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k*32 +: 32] = lane_v[k];
    end
    return v;
  endfunction

  // Lanes k+10 with shift 0 give distinct bytes k+10, handy for spotting
  // lost or repeated transfers.
  task automatic fill_ramp(input int base);
    for (int k = 0; k < 8; k++) begin
      lane_v[k] = 32'(base + k);
      exp_d[k]  = 8'(base + k);
    end
  endtask

  task automatic applyReset();
    rstn_i   = 1'b0;
    en_i     = 1'b0;
    done_i   = 1'b0;
    ready_i  = 1'b0;
    matmul_i = '0;
    shift_i  = '0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Presents one done pulse on the coming rising edge; returns at the
  // following falling edge, where idx 0 should already be visible.
  task automatic applyStimulus(input logic [4:0] sh);
    en_i     = 1'b1;
    done_i   = 1'b1;
    matmul_i = pack_lanes();
    shift_i  = sh;
    @(negedge clk_i);
    done_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({valid_o, busy_o, last_o, ovf_o, sat_o, idx_o, data_o} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0000",
               {valid_o, busy_o, last_o, ovf_o, sat_o, idx_o, data_o});
    end
    applyReset();
    en_i   = 1'b0;
    done_i = 1'b1;
    matmul_i = '1;
    @(negedge clk_i);
    done_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_gate: got valid=%b busy=%b expected 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_basic();
    applyReset();
    ready_i   = 1'b1;
    lane_v[0] = 32'h0000_0100;
    for (int k = 1; k < 8; k++) lane_v[k] = 32'(k);
    exp_d[0] = 8'h10;
    for (int k = 1; k < 8; k++) exp_d[k] = 8'h00;
    applyStimulus(5'd4);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (valid_o !== 1'b1 || idx_o !== 3'(k) || data_o !== exp_d[k] ||
          last_o !== (k == 7) || busy_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_lane%0d: got v=%b idx=%0d d=%h last=%b expected v=1 idx=%0d d=%h last=%b",
                 k, valid_o, idx_o, data_o, last_o, k, exp_d[k], (k == 7));
      end
      @(negedge clk_i);
    end
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || sat_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_end: got v=%b busy=%b sat=%b ovf=%b expected 0 0 0 0",
               valid_o, busy_o, sat_o, ovf_o);
    end
  endtask

  task automatic test_requant();
    applyReset();
    ready_i   = 1'b1;
    lane_v[0] = 32'd24;
    lane_v[1] = 32'd23;
    lane_v[2] = 32'h0000_1000;
    lane_v[3] = -32'sd5;
    lane_v[4] = -32'sh1000;
    lane_v[5] = 32'd127;
    lane_v[6] = 32'd128;
    lane_v[7] = 32'd0;
    exp_d[0] = 8'd2;   exp_d[1] = 8'd1; exp_d[2] = 8'd127; exp_d[3] = 8'd0;
    exp_d[4] = 8'd0;   exp_d[5] = 8'd8; exp_d[6] = 8'd8;   exp_d[7] = 8'd0;
    applyStimulus(5'd4);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (data_o !== exp_d[k] || idx_o !== 3'(k) || sat_o !== (k > 2)) begin
        errors++;
        $display("[TB] FAIL requant_lane%0d: got d=%h idx=%0d sat=%b expected d=%h idx=%0d sat=%b",
                 k, data_o, idx_o, sat_o, exp_d[k], k, (k > 2));
      end
      @(negedge clk_i);
    end
    checks++;
    if (sat_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL requant_end: got sat=%b v=%b expected sat=1 v=0", sat_o, valid_o);
    end
  endtask

  task automatic test_backpressure();
    applyReset();
    ready_i = 1'b1;
    fill_ramp(10);
    applyStimulus(5'd0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (valid_o !== 1'b1 || idx_o !== 3'(k) || data_o !== exp_d[k]) begin
        errors++;
        $display("[TB] FAIL bp_lane%0d: got v=%b idx=%0d d=%h expected v=1 idx=%0d d=%h",
                 k, valid_o, idx_o, data_o, k, exp_d[k]);
      end
      if (k == 3) begin
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk_i);
          checks++;
          if (valid_o !== 1'b1 || idx_o !== 3'd3 || data_o !== exp_d[3] || last_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got v=%b idx=%0d d=%h expected v=1 idx=3 d=%h",
                     c, valid_o, idx_o, data_o, exp_d[3]);
          end
        end
        ready_i = 1'b1;
      end
      @(negedge clk_i);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_end: got v=%b expected 0", valid_o);
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    ready_i = 1'b1;
    fill_ramp(10);
    applyStimulus(5'd0);
    repeat (7) @(negedge clk_i);
    checks++;
    if (idx_o !== 3'd7 || last_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_at_last: got idx=%0d last=%b expected idx=7 last=1", idx_o, last_o);
    end
    fill_ramp(100);
    applyStimulus(5'd0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (valid_o !== 1'b1 || idx_o !== 3'(k) || data_o !== exp_d[k] || ovf_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_lane%0d: got v=%b idx=%0d d=%h ovf=%b expected v=1 idx=%0d d=%h ovf=0",
                 k, valid_o, idx_o, data_o, ovf_o, k, exp_d[k]);
      end
      @(negedge clk_i);
    end
    checks++;
    if (valid_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got v=%b ovf=%b expected 0 0", valid_o, ovf_o);
    end
  endtask

  task automatic test_overflow();
    applyReset();
    ready_i = 1'b1;
    fill_ramp(10);
    applyStimulus(5'd0);
    repeat (4) @(negedge clk_i);
    fill_ramp(50);
    applyStimulus(5'd3);
    fill_ramp(10);
    for (int k = 5; k < 8; k++) begin
      checks++;
      if (idx_o !== 3'(k) || data_o !== exp_d[k] || ovf_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ovf_lane%0d: got idx=%0d d=%h ovf=%b expected idx=%0d d=%h ovf=1",
                 k, idx_o, data_o, ovf_o, k, exp_d[k]);
      end
      @(negedge clk_i);
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || ovf_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got v=%b ovf=%b expected v=0 ovf=1", valid_o, ovf_o);
    end
  endtask

  task automatic test_reset_midstream();
    applyReset();
    ready_i = 1'b1;
    fill_ramp(10);
    applyStimulus(5'd0);
    repeat (5) @(negedge clk_i);
    checks++;
    if (idx_o !== 3'd5) begin
      errors++;
      $display("[TB] FAIL mid_pre: got idx=%0d expected 5", idx_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if ({valid_o, busy_o, last_o, idx_o, data_o} !== 14'h0) begin
      errors++;
      $display("[TB] FAIL mid_async: got v=%b busy=%b idx=%0d d=%h expected all 0",
               valid_o, busy_o, idx_o, data_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_idle: got v=%b busy=%b expected 0 0", valid_o, busy_o);
    end
    applyStimulus(5'd0);
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 3'd0 || data_o !== 8'd10) begin
      errors++;
      $display("[TB] FAIL mid_restart: got v=%b idx=%0d d=%h expected v=1 idx=0 d=0a",
               valid_o, idx_o, data_o);
    end
  endtask

  // Runs every scenario in order and prints the tally.
  initial begin
    checks   = 0;
    errors   = 0;
    rstn_i   = 1'b1;
    en_i     = 1'b0;
    done_i   = 1'b0;
    ready_i  = 1'b0;
    matmul_i = '0;
    shift_i  = '0;
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_requant();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
